denise_colortable_ctrl: RTL and testbench

Write scheduler for the Denise colour look-up RAM. Captures COLORxx and BPLCON3 writes from the custom register bus and queues the colour writes in a small FIFO. It also runs a whole-palette clear sequencer and arbitrates both sources onto the single colour-RAM write port. Sits between the Denise register bus and the colour table RAM; the colour table's read side is untouched.

---
 rtl/denise_colortable_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_denise_colortable_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/denise_colortable_ctrl.sv
// Colour-RAM write scheduler: captures COLORxx/BPLCON3 bus writes, queues colour
// writes and arbitrates them against a whole-palette clear onto one write port.
module denise_colortable_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          CLR_ON_RESET = 1'b1,
    parameter logic [8:0]  BPLCON3_ADR  = 9'h106
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        fifo_ovf,
    output logic [2:0]  bank,
    output logic        loct,
    output logic        ram_wr_en,
    output logic [7:0]  ram_wr_adr,
    output logic [31:0] ram_wr_dat,
    output logic [3:0]  ram_wr_bs
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]  bank;
        logic        loct;
        logic [4:0]  idx;
        logic [11:0] dat;
    } entry_t;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [7:0]        clr_cnt_q, clr_cnt_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic [2:0]        bank_q, bank_d;
    logic              loct_q, loct_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_adr_q, wr_adr_d;
    logic [31:0]       wr_dat_q, wr_dat_d;
    logic [3:0]        wr_bs_q, wr_bs_d;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic   bpl_hit_c, col_hit_c, start_clr_c, pop_c, push_c;
    entry_t head_c, new_c;
    logic   unused_bits_c;

    assign unused_bits_c = ^{data_in[12], data_in[10], BPLCON3_ADR[0]};

    // Bus decode and FIFO handshakes; clear always wins over a pop
    always_comb begin
        bpl_hit_c   = clk7_en && (reg_address_in == BPLCON3_ADR[8:1]);
        col_hit_c   = clk7_en && (reg_address_in[8:6] == 3'b110);
        start_clr_c = (state_q == S_IDLE) && (clr_req || start_q);
        pop_c       = (state_q == S_IDLE) && !start_clr_c && (count_q != '0);
        push_c      = col_hit_c && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_c);
        head_c      = mem_q[rd_ptr_q];
        new_c.bank  = bank_q;
        new_c.loct  = loct_q;
        new_c.idx   = reg_address_in[5:1];
        new_c.dat   = data_in[11:0];
    end

    // Capture registers and colour-write queue
    always_comb begin
        bank_d   = bank_q;
        loct_d   = loct_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (col_hit_c & ~push_c);
        if (bpl_hit_c) begin
            bank_d = data_in[15:13];
            loct_d = data_in[9];
        end
        if (push_c) begin
            mem_d[wr_ptr_q] = new_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear sequencer and write-port arbitration
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        start_d   = 1'b0;
        busy_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_dat_d  = wr_dat_q;
        wr_bs_d   = wr_bs_q;
        case (state_q)
            S_IDLE: begin
                if (start_clr_c) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = 8'd1;
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_adr_d  = 8'd0;
                    wr_dat_d  = 32'd0;
                    wr_bs_d   = 4'b1111;
                end else if (pop_c) begin
                    wr_en_d  = 1'b1;
                    wr_adr_d = {head_c.bank, head_c.idx};
                    wr_dat_d = {4'b0, head_c.dat, 4'b0, head_c.dat};
                    wr_bs_d  = head_c.loct ? 4'b0011 : 4'b1111;
                end
            end
            S_CLEAR: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_adr_d  = clr_cnt_q;
                wr_dat_d  = 32'd0;
                wr_bs_d   = 4'b1111;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= 8'd0;
            start_q   <= CLR_ON_RESET;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bank_q    <= 3'd0;
            loct_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= 8'd0;
            wr_dat_q  <= 32'd0;
            wr_bs_q   <= 4'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            bank_q    <= bank_d;
            loct_q    <= loct_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_dat_q  <= wr_dat_d;
            wr_bs_q   <= wr_bs_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

    assign clr_busy   = busy_q;
    assign fifo_ovf   = ovf_q;
    assign bank       = bank_q;
    assign loct       = loct_q;
    assign ram_wr_en  = wr_en_q;
    assign ram_wr_adr = wr_adr_q;
    assign ram_wr_dat = wr_dat_q;
    assign ram_wr_bs  = wr_bs_q;

endmodule

// File: tb/tb_denise_colortable_ctrl.sv
// Directed bench for denise_colortable_ctrl; expected RAM writes are queued when
// stimulus is driven and compared as the write port produces them.
module tb_denise_colortable_ctrl;

    typedef struct packed {
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  bs;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        clk7_en;
    logic [7:0]  reg_address_in;
    logic [15:0] data_in;
    logic        clr_req;
    logic        clr_busy;
    logic        fifo_ovf;
    logic [2:0]  bank;
    logic        loct;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_adr;
    logic [31:0] ram_wr_dat;
    logic [3:0]  ram_wr_bs;

    int   checks = 0;
    int   errors = 0;
    wr_t  sb [$];
    logic [2:0] bank_m;
    logic       loct_m;

    denise_colortable_ctrl #(
        .FIFO_DEPTH   (4),
        .CLR_ON_RESET (1'b1),
        .BPLCON3_ADR  (9'h106)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .clr_req        (clr_req),
        .clr_busy       (clr_busy),
        .fifo_ovf       (fifo_ovf),
        .bank           (bank),
        .loct           (loct),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_adr     (ram_wr_adr),
        .ram_wr_dat     (ram_wr_dat),
        .ram_wr_bs      (ram_wr_bs)
    );

    initial begin
        clk = 1'b0;
        forever #18 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; any write on the port is matched against the scoreboard head
    task automatic cyc();
        wr_t e;
        @(posedge clk);
        #1;
        if (ram_wr_en !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_en", 32'(ram_wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_adr", 32'(ram_wr_adr), 32'(e.adr));
                chk("wr_dat", ram_wr_dat, e.dat);
                chk("wr_bs", 32'(ram_wr_bs), 32'(e.bs));
            end
        end
    endtask

    task automatic drive_bus(input logic [8:0] a, input logic [15:0] d);
        clk7_en        = 1'b1;
        reg_address_in = a[8:1];
        data_in        = d;
    endtask

    task automatic idle_bus();
        clk7_en        = 1'b0;
        reg_address_in = 8'h00;
        data_in        = 16'h0000;
    endtask

    task automatic exp_clear(input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.adr = 8'(k);
            e.dat = 32'd0;
            e.bs  = 4'b1111;
            sb.push_back(e);
        end
    endtask

    task automatic exp_color(input logic [4:0] idx, input logic [11:0] d);
        wr_t e;
        e.adr = {bank_m, idx};
        e.dat = {4'b0, d, 4'b0, d};
        e.bs  = loct_m ? 4'b0011 : 4'b1111;
        sb.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'd0);
        chk({tag, "_wr_adr"}, 32'(ram_wr_adr), 32'd0);
        chk({tag, "_wr_dat"}, ram_wr_dat, 32'd0);
        chk({tag, "_wr_bs"}, 32'(ram_wr_bs), 32'd0);
        chk({tag, "_bank"}, 32'(bank), 32'd0);
        chk({tag, "_loct"}, 32'(loct), 32'd0);
        chk({tag, "_ovf"}, 32'(fifo_ovf), 32'd0);
        chk({tag, "_busy"}, 32'(clr_busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        clr_req = 1'b0;
        bank_m  = 3'd0;
        loct_m  = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");

        // Auto-clear after reset release
        exp_clear(256);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cyc();
            chk("autoclr_busy", 32'(clr_busy), 32'd1);
        end
        cyc();
        chk("autoclr_busy_end", 32'(clr_busy), 32'd0);
        chk("autoclr_wr_en_end", 32'(ram_wr_en), 32'd0);
        chk("autoclr_drained", 32'(sb.size()), 32'd0);

        // BPLCON3 then COLOR05 with LOCT set
        drive_bus(9'h106, 16'hA200);
        bank_m = 3'd5;
        loct_m = 1'b1;
        cyc();
        idle_bus();
        chk("bank_a200", 32'(bank), 32'd5);
        chk("loct_a200", 32'(loct), 32'd1);
        drive_bus(9'h18A, 16'h0ABC);
        exp_color(5'd5, 12'hABC);
        cyc();
        idle_bus();
        chk("latency_pending", 32'(sb.size()), 32'd1);
        cyc();
        chk("color05_drained", 32'(sb.size()), 32'd0);

        // Snapshot of bank/loct survives a later BPLCON3; clr_req ignored mid-clear
        drive_bus(9'h106, 16'h6000);
        bank_m = 3'd3;
        loct_m = 1'b0;
        cyc();
        idle_bus();
        cyc();
        exp_clear(256);
        for (int i = 0; i < 260; i++) begin
            idle_bus();
            clr_req = (i == 0) || (i == 100);
            if (i == 1) begin
                drive_bus(9'h18A, 16'h0123);
                exp_color(5'd5, 12'h123);
            end
            if (i == 2) begin
                drive_bus(9'h106, 16'hE200);
            end
            cyc();
            if (i == 2) begin
                bank_m = 3'd7;
                loct_m = 1'b1;
            end
            if (i == 255) chk("clr_busy_last", 32'(clr_busy), 32'd1);
            if (i >= 256) chk("clr_busy_after", 32'(clr_busy), 32'd0);
        end
        idle_bus();
        clr_req = 1'b0;
        chk("snapshot_drained", 32'(sb.size()), 32'd0);
        chk("bank_e200", 32'(bank), 32'd7);
        chk("loct_e200", 32'(loct), 32'd1);

        // Six captures during clear into a depth-4 queue
        drive_bus(9'h106, 16'h0000);
        bank_m = 3'd0;
        loct_m = 1'b0;
        cyc();
        idle_bus();
        chk("ovf_before", 32'(fifo_ovf), 32'd0);
        exp_clear(256);
        for (int i = 0; i < 264; i++) begin
            idle_bus();
            clr_req = (i == 0);
            if (i >= 1 && i <= 6) begin
                drive_bus(9'(9'h180 + 2 * (i - 1)), 16'(16'h0100 + (i - 1)));
                if (i <= 4) exp_color(5'(i - 1), 12'(12'h100 + (i - 1)));
            end
            cyc();
            if (i == 4) chk("ovf_at_full", 32'(fifo_ovf), 32'd0);
            if (i == 5) chk("ovf_on_drop", 32'(fifo_ovf), 32'd1);
        end
        idle_bus();
        clr_req = 1'b0;
        chk("ovf_drained", 32'(sb.size()), 32'd0);
        chk("ovf_sticky", 32'(fifo_ovf), 32'd1);

        // Reset during clear with three entries queued
        drive_bus(9'h106, 16'hA200);
        bank_m = 3'd5;
        loct_m = 1'b1;
        cyc();
        idle_bus();
        exp_clear(10);
        for (int i = 0; i < 10; i++) begin
            idle_bus();
            clr_req = (i == 0);
            if (i >= 1 && i <= 3) drive_bus(9'(9'h190 + 2 * i), 16'h0FFF);
            cyc();
        end
        idle_bus();
        clr_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_now");
        cyc();
        cyc();
        chk_reset_vals("rst_hold");
        chk("rst_drained", 32'(sb.size()), 32'd0);

        // Only the auto-clear may follow; the discarded entries must not reappear
        exp_clear(256);
        reset_n = 1'b1;
        for (int i = 0; i < 260; i++) begin
            cyc();
        end
        chk("post_rst_drained", 32'(sb.size()), 32'd0);
        chk("post_rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("post_rst_busy", 32'(clr_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
